// File: rtl/pulse_checker.sv
// pulse_checker: receive-side checker for the BIST pulse generator's out/running/bist_end train.
// Define PULSE_CHECKER_REARM_EN to let a fresh run start from DONE without a reset.
module pulse_checker #(
  parameter int unsigned N_HIGH   = 8,
  parameter int unsigned L_GAP    = 1,
  parameter int unsigned M_PULSES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_in,
  input  logic       running_in,
  input  logic       end_in,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [2:0] err_code,
  output logic [7:0] pulse_cnt
);

  localparam logic [7:0] N_HIGH_C   = 8'(N_HIGH);
  localparam logic [7:0] L_GAP_C    = 8'(L_GAP);
  localparam logic [7:0] M_PULSES_C = 8'(M_PULSES);

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_HIGH  = 3'd1;
  localparam logic [2:0] ERR_GAP   = 3'd2;
  localparam logic [2:0] ERR_CNT   = 3'd3;
  localparam logic [2:0] ERR_PROTO = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] hi_cnt_q, hi_cnt_d;
  logic [7:0] lo_cnt_q, lo_cnt_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;
  logic [2:0] err_q, err_d;
  logic       pulse_prev_q;

  logic       rise_s;
  logic       start_s;
  logic       fin_s;
  logic [2:0] fin_err_s;
  logic [7:0] pcnt_inc_s;

  // State register; the edge detector keeps sampling through reset so a pulse already high is not a new run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hi_cnt_q     <= 8'd0;
      lo_cnt_q     <= 8'd0;
      pcnt_q       <= 8'd0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      err_q        <= ERR_NONE;
      pulse_prev_q <= pulse_in;
    end else begin
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      pcnt_q       <= pcnt_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      err_q        <= err_d;
      pulse_prev_q <= pulse_in;
    end
  end

  // Next-state logic: per-state checks raise fin_s with a code, then a common tail latches the result.
  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    lo_cnt_d   = lo_cnt_q;
    pcnt_d     = pcnt_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = err_q;
    start_s    = 1'b0;
    fin_s      = 1'b0;
    fin_err_s  = ERR_NONE;
    rise_s     = pulse_in & ~pulse_prev_q;
    pcnt_inc_s = sat_inc(pcnt_q);

    case (state_q)
      ST_IDLE: begin
        if (rise_s && running_in) begin
          start_s = 1'b1;
        end else if (rise_s) begin
          fin_s     = 1'b1;
          fin_err_s = ERR_PROTO;
        end else begin
          start_s = 1'b0;
        end
      end
      ST_HIGH: begin
        if (end_in && running_in) begin
          fin_s     = 1'b1;
          fin_err_s = ERR_PROTO;
        end else if (pulse_in) begin
          if (hi_cnt_q == N_HIGH_C) begin
            fin_s     = 1'b1;
            fin_err_s = ERR_HIGH;
          end else begin
            hi_cnt_d = sat_inc(hi_cnt_q);
          end
        end else if (hi_cnt_q != N_HIGH_C) begin
          fin_s     = 1'b1;
          fin_err_s = ERR_HIGH;
        end else begin
          // Completed pulse: the count is updated even when it decides the run.
          pcnt_d = pcnt_inc_s;
          if (running_in && (pcnt_inc_s == M_PULSES_C)) begin
            fin_s     = 1'b1;
            fin_err_s = ERR_CNT;
          end else if (running_in) begin
            state_d  = ST_GAP;
            lo_cnt_d = 8'd1;
          end else if (end_in) begin
            fin_s     = 1'b1;
            fin_err_s = (pcnt_inc_s == M_PULSES_C) ? ERR_NONE : ERR_CNT;
          end else begin
            fin_s     = 1'b1;
            fin_err_s = ERR_PROTO;
          end
        end
      end
      ST_GAP: begin
        if (end_in && running_in) begin
          fin_s     = 1'b1;
          fin_err_s = ERR_PROTO;
        end else if (pulse_in && (lo_cnt_q != L_GAP_C)) begin
          fin_s     = 1'b1;
          fin_err_s = ERR_GAP;
        end else if (!running_in) begin
          fin_s     = 1'b1;
          fin_err_s = end_in ? ERR_CNT : ERR_PROTO;
        end else if (pulse_in) begin
          state_d  = ST_HIGH;
          hi_cnt_d = 8'd1;
        end else if (lo_cnt_q == L_GAP_C) begin
          fin_s     = 1'b1;
          fin_err_s = ERR_GAP;
        end else begin
          lo_cnt_d = sat_inc(lo_cnt_q);
        end
      end
      ST_DONE: begin
`ifdef PULSE_CHECKER_REARM_EN
        if (rise_s && running_in) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
`else
        start_s = 1'b0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_s) begin
      state_d  = ST_HIGH;
      hi_cnt_d = 8'd1;
      lo_cnt_d = 8'd0;
      pcnt_d   = 8'd0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      err_d    = ERR_NONE;
    end else if (fin_s) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      pass_d  = (fin_err_s == ERR_NONE);
      fail_d  = (fin_err_s != ERR_NONE);
      err_d   = fin_err_s;
    end else begin
      done_d = done_q;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign err_code  = err_q;
  assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_pulse_checker.sv
// Scoreboard bench for pulse_checker: stimulus queues expected results, a negedge monitor compares.
module tb_pulse_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pulse_in = 1'b0;
  logic       running_in = 1'b0;
  logic       end_in = 1'b0;
  logic       done, pass, fail;
  logic [2:0] err_code;
  logic [7:0] pulse_cnt;

  pulse_checker #(.N_HIGH(8), .L_GAP(1), .M_PULSES(10)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .running_in(running_in),
    .end_in(end_in), .done(done), .pass(pass), .fail(fail),
    .err_code(err_code), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         rel;
    logic       pass;
    logic       fail;
    logic [2:0] err;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    string      name;
    logic       done;
    logic       pass;
    logic       fail;
    logic [2:0] err;
    logic [7:0] cnt;
  } probe_t;

  exp_t   exp_q[$];
  probe_t probe_q[$];
  exp_t   e_m;
  probe_t p_m;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     t0 = 0;
  int     tcount = 0;
  int     tlimit = 0;
  logic   done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: pops a result on every rising done, and services status probes.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
      end else begin
        e_m = exp_q.pop_front();
        chk({e_m.name, "_cycle"}, cyc - t0, e_m.rel);
        chk({e_m.name, "_pass"}, int'(pass), int'(e_m.pass));
        chk({e_m.name, "_fail"}, int'(fail), int'(e_m.fail));
        chk({e_m.name, "_err"}, int'(err_code), int'(e_m.err));
        chk({e_m.name, "_cnt"}, int'(pulse_cnt), int'(e_m.cnt));
        chk({e_m.name, "_excl"}, int'(pass & fail), 0);
      end
    end
    done_prev <= done;
    while (probe_q.size() > 0) begin
      p_m = probe_q.pop_front();
      chk({p_m.name, "_done"}, int'(done), int'(p_m.done));
      chk({p_m.name, "_pass"}, int'(pass), int'(p_m.pass));
      chk({p_m.name, "_fail"}, int'(fail), int'(p_m.fail));
      chk({p_m.name, "_err"}, int'(err_code), int'(p_m.err));
      chk({p_m.name, "_cnt"}, int'(pulse_cnt), int'(p_m.cnt));
    end
  end

  task automatic expect_done(input string nm, input int rel, input logic ps, input logic fl,
                             input logic [2:0] er, input logic [7:0] cn);
    exp_t e;
    e.name = nm; e.rel = rel; e.pass = ps; e.fail = fl; e.err = er; e.cnt = cn;
    exp_q.push_back(e);
  endtask

  task automatic probe(input string nm, input logic dn, input logic ps, input logic fl,
                       input logic [2:0] er, input logic [7:0] cn);
    probe_t p;
    p.name = nm; p.done = dn; p.pass = ps; p.fail = fl; p.err = er; p.cnt = cn;
    probe_q.push_back(p);
  endtask

  // v = {pulse, running, end}
  task automatic step(input logic [2:0] v);
    @(posedge clk);
    #1;
    pulse_in   = v[2];
    running_in = v[1];
    end_in     = v[0];
  endtask

  task automatic tstep(input logic [2:0] v);
    if (tcount < tlimit) step(v);
    else step(3'b000);
    if (tcount == 0) t0 = cyc;
    tcount++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0; pulse_in = 1'b0; running_in = 1'b0; end_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000);
  endtask

  // Pulse train: 8 high / 1 gap, with one optionally short/long pulse and one optionally long gap.
  task automatic train(input int np, input int bad_p, input int bad_h,
                       input int bad_ga, input int bad_g, input int limit);
    int hl, gl;
    tcount = 0;
    tlimit = limit;
    for (int p = 0; p < np; p++) begin
      hl = (p == bad_p) ? bad_h : 8;
      for (int h = 0; h < hl; h++) tstep(3'b110);
      if (p < np - 1) begin
        gl = (p == bad_ga) ? bad_g : 1;
        for (int g = 0; g < gl; g++) tstep(3'b010);
      end
    end
    tstep(3'b001);
    idle(3);
  endtask

  function automatic logic [2:0] pat(input int c);
    if (c == 89) return 3'b001;
    else if (c < 89) return ((c % 9) != 8) ? 3'b110 : 3'b010;
    else return 3'b000;
  endfunction

  initial begin
    do_reset();
    step(3'b000);
    probe("reset_state", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    idle(2);

    // Protocol: pulse without running in IDLE
    expect_done("proto_idle", 1, 1'b0, 1'b1, 3'd4, 8'd0);
    step(3'b100);
    t0 = cyc;
    idle(4);

    // Protocol: end and running both high mid-pulse at cycle 3
    do_reset();
    idle(2);
    expect_done("proto_mid", 4, 1'b0, 1'b1, 3'd4, 8'd0);
    step(3'b110);
    t0 = cyc;
    step(3'b110);
    step(3'b110);
    step(3'b111);
    idle(4);

    do_reset();
    idle(2);
    expect_done("short_pulse", 26, 1'b0, 1'b1, 3'd1, 8'd2);
    train(10, 2, 7, -1, 1, 26);

    do_reset();
    idle(2);
    expect_done("long_gap", 37, 1'b0, 1'b1, 3'd2, 8'd4);
    train(10, -1, 8, 3, 2, 37);

    do_reset();
    idle(2);
    expect_done("early_end", 81, 1'b0, 1'b1, 3'd3, 8'd9);
    train(9, -1, 8, -1, 1, 1000);

    // Reset mid-run at cycle 40; the remainder of the interrupted pulse must not start a run
    do_reset();
    idle(2);
    for (int c = 0; c < 40; c++) begin
      step(pat(c));
      if (c == 0) t0 = cyc;
      if (c == 8) probe("cnt_before_fall", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      if (c == 9) probe("cnt_after_fall", 1'b0, 1'b0, 1'b0, 3'd0, 8'd1);
      if (c == 39) probe("cnt_at_39", 1'b0, 1'b0, 1'b0, 3'd0, 8'd4);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    {pulse_in, running_in, end_in} = pat(40);
    @(posedge clk);
    #1;
    reset = 1'b1;
    {pulse_in, running_in, end_in} = pat(41);
    probe("midrun_reset", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    for (int c = 42; c < 45; c++) step(pat(c));
    idle(4);
    probe("after_interrupted", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    idle(1);

    expect_done("nominal", 90, 1'b1, 1'b0, 3'd0, 8'd10);
    train(10, -1, 8, -1, 1, 1000);
    idle(2);

    // Second back-to-back run without reset
`ifdef PULSE_CHECKER_REARM_EN
    expect_done("rearm", 90, 1'b1, 1'b0, 3'd0, 8'd10);
    train(10, 2, 7, -1, 1, 0);
    train(10, -1, 8, -1, 1, 1000);
`else
    train(10, 2, 7, -1, 1, 1000);
    probe("frozen", 1'b1, 1'b1, 1'b0, 3'd0, 8'd10);
`endif
    idle(3);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_done: got %0d pending results expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
